// File: rtl/danger_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// danger_scheduler_pkg
// Shared definitions for the obstacle scheduler and the obstacle renderer:
// obstacle type codes, vertical placement rows, obstacle sizes, and the
// mapping from raw LFSR bits to a spawned obstacle type.
//
// Configuration macro: DANGER_BIRD_EN
//   defined   -> LFSR codes 0/1 spawn LOW_BIRD/HIGH_BIRD
//   undefined -> LFSR codes 0/1 spawn BIG_CACTUS (no birds ever appear)
// -----------------------------------------------------------------------------
package danger_scheduler_pkg;

  typedef enum logic [2:0] {
    LOW_BIRD     = 3'd0,
    HIGH_BIRD    = 3'd1,
    SMALL_CACTUS = 3'd2,
    MANY_CACTUS  = 3'd3,
    BIG_CACTUS   = 3'd4,
    NOTHING      = 3'd5
  } danger_type_e;

  localparam int NUM_SLOTS = 3;

  // Vertical rows (y of the obstacle base) shared with the renderer.
  localparam logic [9:0] GROUND   = 10'd400;
  localparam logic [9:0] LOW_SKY  = 10'd360;
  localparam logic [9:0] HIGH_SKY = 10'd320;

  // Obstacle sizes in pixels, shared with the renderer.
  localparam logic [5:0] BIRD_W         = 6'd46;
  localparam logic [5:0] BIRD_H         = 6'd40;
  localparam logic [5:0] SMALL_CACTUS_W = 6'd17;
  localparam logic [5:0] SMALL_CACTUS_H = 6'd35;
  localparam logic [5:0] MANY_CACTUS_W  = 6'd51;
  localparam logic [5:0] MANY_CACTUS_H  = 6'd35;
  localparam logic [5:0] BIG_CACTUS_W   = 6'd25;
  localparam logic [5:0] BIG_CACTUS_H   = 6'd50;

  // Maps three random bits onto a live obstacle type. Never returns NOTHING.
  function automatic danger_type_e map_type(input logic [2:0] code);
    danger_type_e t;
    case (code)
`ifdef DANGER_BIRD_EN
      3'd0:    t = LOW_BIRD;
      3'd1:    t = HIGH_BIRD;
`else
      3'd0:    t = BIG_CACTUS;
      3'd1:    t = BIG_CACTUS;
`endif
      3'd2:    t = SMALL_CACTUS;
      3'd3:    t = MANY_CACTUS;
      3'd4:    t = BIG_CACTUS;
      default: t = SMALL_CACTUS;  // 5/6/7 bias towards the common small cactus
    endcase
    return t;
  endfunction

endpackage

// File: rtl/danger_lfsr.sv
// -----------------------------------------------------------------------------
// danger_lfsr
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10). Shifts every
// clock; only the asynchronous reset holds it. load reloads the seed
// synchronously.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset (state <- RESET_VALUE)
//   load  in   synchronous reload of seed
//   seed  in   16-bit reload value (must be nonzero)
//   lfsr  out  current LFSR state
// -----------------------------------------------------------------------------
module danger_lfsr #(
  parameter logic [15:0] RESET_VALUE = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  logic feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= RESET_VALUE;
    end else if (load) begin
      lfsr <= seed;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

endmodule

// File: rtl/danger_scheduler.sv
// -----------------------------------------------------------------------------
// danger_scheduler
// Upstream feeder of the obstacle renderer. Owns three obstacle slots; on each
// accepted game tick it scrolls live slots left, retires slots that leave the
// screen, and spawns new obstacles with pseudo-random type and gap.
//
// Configuration macro: DANGER_BIRD_EN (see danger_scheduler_pkg::map_type).
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-low reset
//   restart         in   1-cycle pulse: clear slots, reload gap and LFSR
//   run             in   1 = game running, 0 = freeze all but the LFSR
//   game_tick       in   one scroll step per cycle it is high
//   speed[2:0]      in   pixels moved per tick
//   danger_posN     out  slot N right-edge x (registered)
//   danger_typeN    out  slot N type code, NOTHING when idle (registered)
//   danger_enN      out  slot N live (registered)
// -----------------------------------------------------------------------------
module danger_scheduler
  import danger_scheduler_pkg::*;
#(
  parameter logic [9:0]  SPAWN_X   = 10'd700,
  parameter int          FIRST_GAP = 60,
  parameter int          MIN_GAP   = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       run,
  input  logic       game_tick,
  input  logic [2:0] speed,
  output logic [9:0] danger_pos1,
  output logic [9:0] danger_pos2,
  output logic [9:0] danger_pos3,
  output logic [2:0] danger_type1,
  output logic [2:0] danger_type2,
  output logic [2:0] danger_type3,
  output logic       danger_en1,
  output logic       danger_en2,
  output logic       danger_en3
);

  // Largest reload is MIN_GAP + 63, which fits 7 bits for the default set.
  localparam int GAP_W = 7;
  localparam logic [GAP_W-1:0] FIRST_GAP_C = GAP_W'(FIRST_GAP);
  localparam logic [GAP_W-1:0] MIN_GAP_C   = GAP_W'(MIN_GAP);
  localparam logic [NUM_SLOTS-1:0][2:0] ALL_NOTHING = {NUM_SLOTS{3'(NOTHING)}};

  logic [15:0] lfsr;
  logic        unused_lfsr_bits;

  logic [NUM_SLOTS-1:0]       en_q,  en_d,  scr_en;
  logic [NUM_SLOTS-1:0][9:0]  pos_q, pos_d, scr_pos;
  logic [NUM_SLOTS-1:0][2:0]  typ_q, typ_d, scr_typ;
  logic [GAP_W-1:0]           gap_q, gap_d;

  logic [9:0] speed_x;
  logic       tick_ok;

  danger_lfsr #(
    .RESET_VALUE(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (restart),
    .seed (LFSR_SEED),
    .lfsr (lfsr)
  );

  // Only the low six bits feed the scheduler; the rest just stir the sequence.
  assign unused_lfsr_bits = ^lfsr[15:6];

  assign speed_x = {7'd0, speed};
  assign tick_ok = run && game_tick;

  // Per-slot scroll/retire. A live slot whose edge would reach or cross x=0
  // this tick is retired instead, so the subtraction never wraps.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : gen_slot
    logic retire;
    assign retire     = en_q[g] && (pos_q[g] <= speed_x);
    assign scr_en[g]  = en_q[g] && !retire;
    assign scr_pos[g] = retire ? 10'd0 :
                        (en_q[g] ? pos_q[g] - speed_x : pos_q[g]);
    assign scr_typ[g] = retire ? 3'(NOTHING) : typ_q[g];
  end

  // Gap counter semantics: it holds the number of ticks until a spawn is due.
  // The tick that brings it to zero (or finds it already at zero because all
  // slots were busy) attempts the spawn, so consecutive spawns are exactly
  // MIN_GAP + lfsr[5:0] ticks apart and the first comes FIRST_GAP ticks after
  // restart.
  always_comb begin
    logic             found;
    logic [GAP_W-1:0] gap_next;
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    en_d     = en_q;
    pos_d    = pos_q;
    typ_d    = typ_q;
    gap_d    = gap_q;
    found    = 1'b0;
    gap_next = gap_q;

    if (restart) begin
      en_d  = '0;
      pos_d = '0;
      typ_d = ALL_NOTHING;
      gap_d = FIRST_GAP_C;
    end else if (tick_ok) begin
      en_d  = scr_en;
      pos_d = scr_pos;
      typ_d = scr_typ;

      if (gap_q != '0) begin
        gap_next = gap_q - 1'b1;
      end

      if (gap_next == '0) begin
        // Lowest-index free slot wins; a slot just retired is eligible.
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (!found && !scr_en[i]) begin
            found    = 1'b1;
            en_d[i]  = 1'b1;
            pos_d[i] = SPAWN_X;
            typ_d[i] = map_type(lfsr[2:0]);
          end
        end
        if (found) begin
          gap_next = MIN_GAP_C + GAP_W'(lfsr[5:0]);
        end
      end
      gap_d = gap_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q  <= '0;
      pos_q <= '0;
      typ_q <= ALL_NOTHING;
      gap_q <= FIRST_GAP_C;
    end else begin
      en_q  <= en_d;
      pos_q <= pos_d;
      typ_q <= typ_d;
      gap_q <= gap_d;
    end
  end

  assign danger_pos1  = pos_q[0];
  assign danger_pos2  = pos_q[1];
  assign danger_pos3  = pos_q[2];
  assign danger_type1 = typ_q[0];
  assign danger_type2 = typ_q[1];
  assign danger_type3 = typ_q[2];
  assign danger_en1   = en_q[0];
  assign danger_en2   = en_q[1];
  assign danger_en3   = en_q[2];

endmodule

// File: tb/tb_danger_scheduler.sv
// -----------------------------------------------------------------------------
// tb_danger_scheduler
// Self-checking bench: a behavioural model of the three obstacle slots, the
// gap countdown and the LFSR is stepped on every clock edge and compared with
// all DUT outputs one time unit later. Directed phases pin the first-spawn
// timing, scrolling, freeze and restart with literal expectations; a random
// phase follows.
// -----------------------------------------------------------------------------
module tb_danger_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic       run;
  logic       game_tick;
  logic [2:0] speed;
  logic [9:0] danger_pos1, danger_pos2, danger_pos3;
  logic [2:0] danger_type1, danger_type2, danger_type3;
  logic       danger_en1, danger_en2, danger_en3;

  always #5 clk = ~clk;

  danger_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .run          (run),
    .game_tick    (game_tick),
    .speed        (speed),
    .danger_pos1  (danger_pos1),
    .danger_pos2  (danger_pos2),
    .danger_pos3  (danger_pos3),
    .danger_type1 (danger_type1),
    .danger_type2 (danger_type2),
    .danger_type3 (danger_type3),
    .danger_en1   (danger_en1),
    .danger_en2   (danger_en2),
    .danger_en3   (danger_en3)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int          m_en  [3];
  int          m_pos [3];
  int          m_typ [3];
  int          m_gap;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    // taps 16,14,13,11 -> bits 15,13,12,10
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic int map_code(input int c);
`ifdef DANGER_BIRD_EN
    if (c <= 4) return c;
`else
    if (c <= 1) return 4;
    if (c <= 4) return c;
`endif
    return 2;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_en[i]  = 0;
      m_pos[i] = 0;
      m_typ[i] = 5;
    end
    m_gap  = 60;
    m_lfsr = 16'hACE1;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at it.
  task automatic model_edge();
    int free_list[$];
    int s;
    if (!rst || restart) begin
      model_clear();
      return;
    end
    if (run && game_tick) begin
      for (int i = 0; i < 3; i++) begin
        if (m_en[i] != 0) begin
          if (m_pos[i] <= int'(speed)) begin
            m_en[i] = 0; m_pos[i] = 0; m_typ[i] = 5;
          end else begin
            m_pos[i] = m_pos[i] - int'(speed);
          end
        end
      end
      if (m_gap > 0) m_gap--;
      if (m_gap == 0) begin
        for (int i = 0; i < 3; i++) if (m_en[i] == 0) free_list.push_back(i);
        if (free_list.size() > 0) begin
          s = free_list[0];
          m_en[s]  = 1;
          m_pos[s] = 700;
          m_typ[s] = map_code(int'(m_lfsr) % 8);
          m_gap    = 40 + int'(m_lfsr) % 64;
        end
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all();
    int a_en, a_pos, a_typ;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a_en = int'(danger_en1); a_pos = int'(danger_pos1); a_typ = int'(danger_type1); end
        1:       begin a_en = int'(danger_en2); a_pos = int'(danger_pos2); a_typ = int'(danger_type2); end
        default: begin a_en = int'(danger_en3); a_pos = int'(danger_pos3); a_typ = int'(danger_type3); end
      endcase
      check($sformatf("slot%0d_en", i + 1), a_en, m_en[i]);
      check($sformatf("slot%0d_pos", i + 1), a_pos, m_pos[i]);
      check($sformatf("slot%0d_type", i + 1), a_typ, m_typ[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic tick();
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
  endtask

  function automatic bit model_all_live();
    return (m_en[0] != 0) && (m_en[1] != 0) && (m_en[2] != 0);
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b0;
    restart   = 1'b0;
    run       = 1'b1;
    game_tick = 1'b0;
    speed     = 3'd4;
    model_clear();

    // Reset state.
    repeat (3) step();
    check("reset_en",   {danger_en1, danger_en2, danger_en3}, 0);
    check("reset_type", {danger_type1, danger_type2, danger_type3}, 9'h16D);
    rst = 1'b1;

    // First spawn: 59 empty ticks, then slot1 at 700 on tick 60 (tick every 10 clk).
    for (int k = 1; k <= 60; k++) begin
      repeat (9) step();
      tick();
      if (k == 59) check("empty_at_tick59", {danger_en1, danger_en2, danger_en3}, 0);
    end
    check("tick60_en1",  danger_en1, 1);
    check("tick60_pos1", danger_pos1, 700);
    check("tick60_en23", {danger_en2, danger_en3}, 0);

    // Five ticks at speed 4 move slot1 to 680.
    for (int k = 0; k < 5; k++) begin
      repeat (9) step();
      tick();
    end
    check("five_ticks_pos1", danger_pos1, 680);

    // Run down to retirement at speed 4 (model checks each cycle).
    for (int k = 0; k < 200; k++) begin
      tick();
      step();
    end

    // Freeze: 20 ticks with run=0, then resume.
    run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      step();
    end
    run = 1'b1;
    for (int k = 0; k < 20; k++) tick();

    // Fill all three slots slowly, then restart mid-game.
    speed = 3'd1;
    n = 0;
    while (!model_all_live() && n < 3000) begin
      tick();
      n++;
    end
    check("three_live_reached", int'(n < 3000), 1);
    // All three live with spawn due: ticks keep retrying until a slot frees.
    for (int k = 0; k < 120; k++) tick();

    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_en",   {danger_en1, danger_en2, danger_en3}, 0);
    check("restart_type", {danger_type1, danger_type2, danger_type3}, 9'h16D);
    n = 0;
    while (!danger_en1 && n < 200) begin
      tick();
      n++;
    end
    check("restart_first_spawn_ticks", n, 60);

    // Random phase: retire/respawn at assorted speeds, freezes, restarts.
    speed = 3'd5;
    for (int c = 0; c < 15000; c++) begin
      if ($urandom_range(0, 199) == 0) speed = 3'($urandom_range(0, 7));
      run       = ($urandom_range(0, 19) != 0);
      game_tick = ($urandom_range(0, 1) == 1);
      restart   = ($urandom_range(0, 3999) == 0);
      step();
    end
    restart   = 1'b0;
    game_tick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
